// File: rtl/uart_tx_sched_pkg.sv
// uart_tx_sched_pkg: shared FSM encoding, word width and clog2 helper for the UART TX scheduler
package uart_tx_sched_pkg;
  localparam int UART_WORD_W = 32;
  typedef enum logic {ST_IDLE, ST_XFER} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if: requester side and TX-engine FIFO side of the UART TX scheduler
interface uart_tx_sched_if
  import uart_tx_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_DEPTH = 16
);
  logic                           sched_en;
  logic [NUM_REQ-1:0]             req_valid;
  logic [UART_WORD_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]             req_lock;
  logic [NUM_REQ-1:0]             req_ready;
  logic                           clk_en;
  logic [UART_WORD_W-1:0]         tx_fifo_rd_data;
  logic                           tx_fifo_rd_data_valid;
  logic                           tx_fifo_rd_data_req;
  logic [clog2(FIFO_DEPTH):0]     fifo_level;
  logic                           busy;
  modport master (
    output sched_en, req_valid, req_data, req_lock, tx_fifo_rd_data_req,
    input  req_ready, clk_en, tx_fifo_rd_data, tx_fifo_rd_data_valid, fifo_level, busy
  );
  modport slave (
    input  sched_en, req_valid, req_data, req_lock, tx_fifo_rd_data_req,
    output req_ready, clk_en, tx_fifo_rd_data, tx_fifo_rd_data_valid, fifo_level, busy
  );
endinterface

// File: rtl/uart_tx_sched_fifo.sv
// uart_tx_sched_fifo: synchronous first-word-fall-through FIFO; head reads 0 while empty
module uart_tx_sched_fifo
  import uart_tx_sched_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = UART_WORD_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic [WIDTH-1:0]        rd_data,
  output logic                    empty,
  output logic                    full,
  output logic [clog2(DEPTH):0]   level
);
  localparam int AW = clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;
  assign empty   = level == '0;
  assign full    = level == LW'(DEPTH);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= push_data;
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin arbiter feeding a TX word FIFO, plus the engine's clk_en divider.
// Define UART_TX_SCHED_LOCK_EN to let a locked requester keep its grant for consecutive words.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int CLK_EN_DIV = 72
) (
  input logic           clk,
  input logic           rst_n,
  uart_tx_sched_if.slave bus
);
  localparam int IW = clog2(NUM_REQ);
  localparam int DW = clog2(CLK_EN_DIV);
  state_t                 state;
  logic [IW-1:0]          gnt_idx, last_gnt, next_idx;
  logic [DW-1:0]          div;
  logic [UART_WORD_W-1:0] push_data;
  logic                   push, full, empty, hold;
  assign bus.clk_en = div == DW'(CLK_EN_DIV - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) div <= '0;
    else div <= bus.clk_en ? '0 : div + 1'b1;
  // descending scan so the nearest valid index after last_gnt is the one left standing
  always_comb begin
    next_idx = last_gnt;
    for (int k = NUM_REQ; k >= 1; k--)
      if (bus.req_valid[(int'(last_gnt) + k) % NUM_REQ]) next_idx = IW'((int'(last_gnt) + k) % NUM_REQ);
  end
  assign push          = state == ST_XFER && bus.req_valid[gnt_idx] && !full;
  assign push_data     = bus.req_data[gnt_idx*UART_WORD_W +: UART_WORD_W];
  assign bus.req_ready = push ? NUM_REQ'(1) << gnt_idx : '0;
  assign bus.busy      = state != ST_IDLE || !empty;
  assign bus.tx_fifo_rd_data_valid = !empty;
`ifdef UART_TX_SCHED_LOCK_EN
  assign hold = bus.req_lock[gnt_idx] && bus.sched_en;
`else
  logic unused_lock;
  assign unused_lock = ^bus.req_lock;
  assign hold = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= ST_IDLE;
      gnt_idx  <= '0;
      last_gnt <= IW'(NUM_REQ - 1);
    end else if (state == ST_IDLE) begin
      if (bus.sched_en && |bus.req_valid && !full) begin
        gnt_idx <= next_idx;
        state   <= ST_XFER;
      end
    end else if (push) begin
      last_gnt <= gnt_idx;
      state    <= hold ? ST_XFER : ST_IDLE;
    end else if (!bus.req_valid[gnt_idx]) state <= ST_IDLE;
  uart_tx_sched_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(UART_WORD_W)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (bus.tx_fifo_rd_data_req),
    .rd_data   (bus.tx_fifo_rd_data),
    .empty     (empty),
    .full      (full),
    .level     (bus.fifo_level)
  );
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed and randomized traffic against a queue-based arbiter/FIFO reference model
module tb_uart_tx_sched;
`ifdef UART_TX_SCHED_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n;
  int tests = 0, fails = 0;
  logic [31:0] wq [4][$];
  bit lk [4];
  logic [31:0] sb [$];
  int exp_order [$];
  int acc_cyc [$];
  int m_last = 3;
  int n_acc = 0;
  logic [31:0] second_word;
  int base_acc;
  uart_tx_sched_if #(.NUM_REQ(4), .FIFO_DEPTH(16)) bus ();
  uart_tx_sched #(.NUM_REQ(4), .FIFO_DEPTH(16), .CLK_EN_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // expected grant sequence: round robin over requesters with words left; a locked grant drains its owner
  task automatic plan();
    int cnt [4];
    int last, cur, total, n;
    exp_order.delete();
    total = 0;
    for (int i = 0; i < 4; i++) begin
      cnt[i] = wq[i].size();
      total += cnt[i];
    end
    last = m_last;
    cur = -1;
    while (total > 0) begin
      n = -1;
      if (LOCK && cur >= 0 && lk[cur] && cnt[cur] > 0) n = cur;
      else
        for (int k = 4; k >= 1; k--)
          if (cnt[(last + k) % 4] > 0) n = (last + k) % 4;
      exp_order.push_back(n);
      cnt[n]--;
      total--;
      last = n;
      cur = n;
    end
  endtask
  // pmode: 0 no pops, 1 random pops, 2 pop every cycle, 3 pop only when a word is being accepted
  task automatic run(input int ncyc, input int pmode, input bit until_done, input int stop_level);
    bit done, pop, do_pop;
    logic [3:0] rdy;
    int idx;
    done = 1'b0;
    acc_cyc.delete();
    for (int c = 0; c < ncyc; c++) begin
      for (int i = 0; i < 4; i++) begin
        bus.req_valid[i] = wq[i].size() > 0;
        bus.req_lock[i]  = lk[i] && wq[i].size() > 0;
        bus.req_data[32*i +: 32] = wq[i].size() > 0 ? wq[i][0] : 32'h0;
      end
      #1;
      pop = pmode == 2 || (pmode == 1 && $urandom_range(0, 1) == 1) || (pmode == 3 && |bus.req_ready);
      bus.tx_fifo_rd_data_req = pop;
      @(negedge clk);
      rdy = bus.req_ready;
      check("level", 32'(bus.fifo_level), 32'(sb.size()));
      check("valid", 32'(bus.tx_fifo_rd_data_valid), 32'(sb.size() > 0));
      if (sb.size() > 0) check("head", bus.tx_fifo_rd_data, sb[0]);
      if (sb.size() == 16) check("ready_full", 32'(rdy), 32'h0);
      do_pop = pop && sb.size() > 0;
      if (rdy != 4'h0) begin
        idx = 0;
        for (int i = 3; i >= 0; i--) if (rdy[i]) idx = i;
        check("ready_onehot", 32'($countones(rdy)), 32'd1);
        check("gnt_idx", 32'(idx), exp_order.size() > 0 ? 32'(exp_order[0]) : 32'hdead);
        if (exp_order.size() > 0) void'(exp_order.pop_front());
        if (wq[idx].size() > 0) sb.push_back(wq[idx].pop_front());
        m_last = idx;
        acc_cyc.push_back(c);
        n_acc++;
      end
      if (do_pop) void'(sb.pop_front());
      @(posedge clk);
      #1;
      if (until_done && wq[0].size() + wq[1].size() + wq[2].size() + wq[3].size() == 0 &&
          (pmode == 0 || pmode == 3 || sb.size() == 0)) begin
        done = 1'b1;
        break;
      end
      if (stop_level >= 0 && sb.size() == stop_level) break;
    end
    bus.tx_fifo_rd_data_req = 1'b0;
    if (until_done) check("timeout", 32'(done), 32'd1);
  endtask
  initial begin
    rst_n = 1'b0;
    bus.sched_en = 1'b1;
    bus.req_valid = '0;
    bus.req_lock = '0;
    bus.req_data = '0;
    bus.tx_fifo_rd_data_req = 1'b0;
    for (int i = 0; i < 4; i++) lk[i] = 1'b0;
    // reset state and clk_en cadence
    repeat (3) @(posedge clk);
    #1;
    check("rst_level", 32'(bus.fifo_level), 32'h0);
    check("rst_valid", 32'(bus.tx_fifo_rd_data_valid), 32'h0);
    check("rst_rd_data", bus.tx_fifo_rd_data, 32'h0);
    check("rst_ready", 32'(bus.req_ready), 32'h0);
    check("rst_clk_en", 32'(bus.clk_en), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check($sformatf("clk_en_c%0d", c), 32'(bus.clk_en), 32'(c % 4 == 3));
      @(posedge clk);
      #1;
    end
    // fairness from reset and 2-cycle grant spacing
    for (int i = 0; i < 4; i++) wq[i].push_back(32'hA000_0000 + 32'(i));
    plan();
    run(40, 0, 1, -1);
    check("first_ready_cycle", 32'(acc_cyc.size() > 0 ? acc_cyc[0] : -1), 32'd1);
    for (int k = 1; k < 4; k++)
      check("ready_spacing", 32'(acc_cyc.size() > k ? acc_cyc[k] - acc_cyc[k-1] : -1), 32'd2);
    check("order_head", bus.tx_fifo_rd_data, 32'hA000_0000);
    check("order_level", 32'(bus.fifo_level), 32'd4);
    check("busy_nonempty", 32'(bus.busy), 32'd1);
    run(100, 1, 1, -1);
    // fill to full with a single requester, then one pop lets exactly one more word in
    for (int k = 0; k < 18; k++) wq[1].push_back($urandom);
    plan();
    run(60, 0, 0, -1);
    check("full_level", 32'(bus.fifo_level), 32'd16);
    base_acc = n_acc;
    run(1, 2, 0, -1);
    run(6, 0, 0, -1);
    check("refill_level", 32'(bus.fifo_level), 32'd16);
    check("refill_one_word", 32'(n_acc - base_acc), 32'd1);
    run(200, 1, 1, -1);
    // simultaneous push and pop at level 5, then pops on an empty FIFO
    for (int k = 0; k < 5; k++) wq[2].push_back($urandom);
    second_word = wq[2][1];
    plan();
    run(30, 0, 1, -1);
    check("level5", 32'(bus.fifo_level), 32'd5);
    wq[3].push_back($urandom);
    plan();
    run(10, 3, 1, -1);
    check("pushpop_level", 32'(bus.fifo_level), 32'd5);
    check("pushpop_head", bus.tx_fifo_rd_data, second_word);
    run(100, 1, 1, -1);
    run(3, 2, 0, -1);
    check("empty_pop_level", 32'(bus.fifo_level), 32'd0);
    check("empty_pop_valid", 32'(bus.tx_fifo_rd_data_valid), 32'd0);
    // locked 3-word message from req2 competing with req0
    wq[2].push_back(32'h2A); wq[2].push_back(32'h2B); wq[2].push_back(32'h2C);
    wq[0].push_back(32'h0F);
    lk[2] = 1'b1;
    plan();
    run(60, 1, 1, -1);
    lk[2] = 1'b0;
    // sched_en low: pending requests get no grant until it returns
    wq[1].push_back($urandom); wq[3].push_back($urandom);
    plan();
    bus.sched_en = 1'b0;
    base_acc = n_acc;
    run(12, 0, 0, -1);
    check("sched_en_off", 32'(n_acc - base_acc), 32'd0);
    bus.sched_en = 1'b1;
    run(100, 1, 1, -1);
    // randomized rounds
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 4; i++) begin
        int n;
        n = $urandom_range(0, 5);
        for (int k = 0; k < n; k++) wq[i].push_back($urandom);
        lk[i] = $urandom_range(0, 1) == 1;
      end
      plan();
      run(300, 1, 1, -1);
    end
    for (int i = 0; i < 4; i++) lk[i] = 1'b0;
    // reset in the middle of a transfer at level 7
    for (int k = 0; k < 10; k++) wq[1].push_back($urandom);
    plan();
    run(40, 0, 0, 7);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_level", 32'(bus.fifo_level), 32'd0);
    check("mid_rst_ready", 32'(bus.req_ready), 32'd0);
    check("mid_rst_clk_en", 32'(bus.clk_en), 32'd0);
    check("mid_rst_valid", 32'(bus.tx_fifo_rd_data_valid), 32'd0);
    for (int i = 0; i < 4; i++) wq[i].delete();
    sb.delete();
    m_last = 3;
    bus.req_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wq[2].push_back(32'h1234_5678); wq[0].push_back(32'h8765_4321);
    plan();
    run(40, 1, 1, -1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
